// File: rtl/pll_loop_filter_gs.sv
// Gear-shift PI loop filter for a PFD-driven PLL: integrates up/down error with
// anti-windup, drives a clamped signed control word, and narrows gains once quiet.
module pll_loop_filter_gs #(
  parameter int OUT_W         = 16,
  parameter int ACC_W         = 32,
  parameter int KP_ACQ        = 7,
  parameter int KI_ACQ        = 4,
  parameter int KP_TRK        = 2,
  parameter int KI_TRK        = 1,
  parameter int LOCK_CYCLES   = 64,
  parameter int UNLOCK_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    up,
  input  logic                    down,
  input  logic                    hold,
  output logic signed [OUT_W-1:0] ctrl,
  output logic                    locked,
  output logic                    sat,
  output logic [1:0]              state
);

  if (ACC_W < OUT_W + 1) begin : g_bad_acc_w
    $error("ACC_W must be at least OUT_W+1");
  end
  if (LOCK_CYCLES < 1 || UNLOCK_CYCLES < 1) begin : g_bad_cycles
    $error("LOCK_CYCLES and UNLOCK_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_ACQ  = 2'b00,
    ST_TRK  = 2'b01,
    ST_HOLD = 2'b10
  } state_t;

  // One guard bit above the integrator so acc + gain*e can never wrap.
  localparam int SUM_W = ACC_W + 1;
  localparam int QW    = $clog2(LOCK_CYCLES + 1);
  localparam int SW    = $clog2(UNLOCK_CYCLES + 1);

  localparam logic signed [SUM_W-1:0] LIM_HI = {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] LIM_LO = {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic signed [OUT_W-1:0] OUT_HI = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_LO = {1'b1, {(OUT_W-1){1'b0}}};

  localparam logic signed [SUM_W-1:0] KP_ACQ_W = SUM_W'(KP_ACQ);
  localparam logic signed [SUM_W-1:0] KI_ACQ_W = SUM_W'(KI_ACQ);
  localparam logic signed [SUM_W-1:0] KP_TRK_W = SUM_W'(KP_TRK);
  localparam logic signed [SUM_W-1:0] KI_TRK_W = SUM_W'(KI_TRK);

  function automatic logic signed [OUT_W-1:0] clamp_val(input logic signed [SUM_W-1:0] v);
    if (v > LIM_HI)      clamp_val = OUT_HI;
    else if (v < LIM_LO) clamp_val = OUT_LO;
    else                 clamp_val = v[OUT_W-1:0];
  endfunction

  function automatic logic clamp_hit(input logic signed [SUM_W-1:0] v);
    clamp_hit = (v > LIM_HI) || (v < LIM_LO);
  endfunction

  state_t                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [OUT_W-1:0]   ctrl_q, ctrl_d;
  logic                      sat_q, sat_d;
  logic                      locked_q, locked_d;
  logic [QW-1:0]             quiet_q, quiet_d;
  logic [SW-1:0]             slip_q, slip_d;
  logic                      neg_q, neg_d;

  logic                      err_pos, err_neg, err_nz, freeze;
  logic signed [SUM_W-1:0]   kp, ki, kp_term, ki_term;
  logic signed [SUM_W-1:0]   acc_sum, out_sum;
  logic signed [OUT_W-1:0]   acc_cl, out_cl;
  logic [SW-1:0]             slip_nxt;

  always_comb begin
    err_pos = up & ~down;
    err_neg = down & ~up;
    err_nz  = err_pos | err_neg;
    freeze  = hold || (state_q == ST_HOLD);

    kp = (state_q == ST_TRK) ? KP_TRK_W : KP_ACQ_W;
    ki = (state_q == ST_TRK) ? KI_TRK_W : KI_ACQ_W;
    kp_term = err_pos ? kp : (err_neg ? -kp : '0);
    ki_term = err_pos ? ki : (err_neg ? -ki : '0);

    // Integrator is clamped first, then the proportional path rides on top.
    acc_sum = {acc_q[ACC_W-1], acc_q} + ki_term;
    acc_cl  = clamp_val(acc_sum);
    out_sum = {{(SUM_W-OUT_W){acc_cl[OUT_W-1]}}, acc_cl} + kp_term;
    out_cl  = clamp_val(out_sum);

    state_d  = state_q;
    acc_d    = acc_q;
    ctrl_d   = acc_q[OUT_W-1:0];
    sat_d    = 1'b0;
    quiet_d  = quiet_q;
    slip_d   = slip_q;
    neg_d    = neg_q;
    slip_nxt = '0;

    if (freeze) begin
      quiet_d = '0;
      slip_d  = '0;
      state_d = hold ? ST_HOLD : ST_ACQ;
    end else begin
      acc_d  = {{(ACC_W-OUT_W){acc_cl[OUT_W-1]}}, acc_cl};
      ctrl_d = out_cl;
      sat_d  = clamp_hit(acc_sum) | clamp_hit(out_sum);
      case (state_q)
        ST_ACQ: begin
          slip_d = '0;
          if (err_nz) begin
            quiet_d = '0;
          end else if (quiet_q >= QW'(LOCK_CYCLES - 1)) begin
            quiet_d = '0;
            state_d = ST_TRK;
          end else begin
            quiet_d = quiet_q + 1'b1;
          end
        end
        ST_TRK: begin
          quiet_d = '0;
          if (!err_nz) begin
            slip_d = '0;
          end else begin
            // A run only continues while the error keeps the same sign.
            slip_nxt = (slip_q != '0 && neg_q == err_neg) ? slip_q + 1'b1 : SW'(1);
            neg_d    = err_neg;
            if (slip_nxt >= SW'(UNLOCK_CYCLES)) begin
              slip_d  = '0;
              state_d = ST_ACQ;
            end else begin
              slip_d = slip_nxt;
            end
          end
        end
        default: state_d = ST_HOLD;
      endcase
    end

    locked_d = (state_d == ST_TRK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_ACQ;
      acc_q    <= '0;
      ctrl_q   <= '0;
      sat_q    <= 1'b0;
      locked_q <= 1'b0;
      quiet_q  <= '0;
      slip_q   <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      ctrl_q   <= ctrl_d;
      sat_q    <= sat_d;
      locked_q <= locked_d;
      quiet_q  <= quiet_d;
      slip_q   <= slip_d;
      neg_q    <= neg_d;
    end
  end

  assign ctrl   = ctrl_q;
  assign locked = locked_q;
  assign sat    = sat_q;
  assign state  = state_q;

endmodule

// File: tb/tb_pll_loop_filter_gs.sv
// Scoreboard bench for pll_loop_filter_gs: directed stimulus pushes hand-computed
// expectations, a monitor pops one per checked clock edge and compares.
module tb_pll_loop_filter_gs;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               up = 1'b0;
  logic               down = 1'b0;
  logic               hold = 1'b0;
  logic signed [15:0] ctrl;
  logic               locked;
  logic               sat;
  logic [1:0]         state;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic signed [15:0] ctrl;
    logic               lk;
    logic               sat;
    logic [1:0]         st;
    string              name;
  } exp_t;

  exp_t sb[$];

  pll_loop_filter_gs dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .up     (up),
    .down   (down),
    .hold   (hold),
    .ctrl   (ctrl),
    .locked (locked),
    .sat    (sat),
    .state  (state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: timeout, %0d expectations pending", sb.size());
    $fatal(1, "timeout");
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && sb.size() > 0) begin
      e = sb.pop_front();
      n_tests++;
      if (ctrl !== e.ctrl || locked !== e.lk || sat !== e.sat || state !== e.st) begin
        n_fail++;
        $display("FAIL %s: got ctrl=%0d locked=%b sat=%b state=%b, expected ctrl=%0d locked=%b sat=%b state=%b",
                 e.name, ctrl, locked, sat, state, e.ctrl, e.lk, e.sat, e.st);
      end
    end
  end

  task automatic step(input logic u, input logic d, input logic h);
    @(negedge clk);
    up = u;
    down = d;
    hold = h;
  endtask

  task automatic expect_out(input int c, input logic lk, input logic s, input logic [1:0] st,
                            input string nm);
    exp_t x;
    x.ctrl = 16'(c);
    x.lk   = lk;
    x.sat  = s;
    x.st   = st;
    x.name = nm;
    sb.push_back(x);
  endtask

  task automatic do_reset();
    @(negedge clk);
    up = 1'b0; down = 1'b0; hold = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state and asynchronous reset with acc=500.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0); expect_out(0, 0, 0, 2'b00, "reset_idle");
    end
    for (int i = 1; i <= 125; i++) begin
      step(1, 0, 0);
      if (i == 125) expect_out(507, 0, 0, 2'b00, "acc500_up");
    end
    step(0, 0, 0); expect_out(500, 0, 0, 2'b00, "acc500_idle");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (ctrl !== 16'sd0 || locked !== 1'b0 || sat !== 1'b0 || state !== 2'b00) begin
      n_fail++;
      $display("FAIL async_reset: got ctrl=%0d locked=%b sat=%b state=%b, expected all 0",
               ctrl, locked, sat, state);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // ACQ proportional + integral response.
    step(1, 0, 0); expect_out(11, 0, 0, 2'b00, "acq_up");
    step(0, 0, 0); expect_out(4, 0, 0, 2'b00, "acq_up_idle");
    step(0, 1, 0); expect_out(-7, 0, 0, 2'b00, "acq_down");
    step(0, 0, 0); expect_out(0, 0, 0, 2'b00, "acq_down_idle");

    // Lock count, restarted by errors, with up&down cycles counting as quiet.
    do_reset();
    for (int i = 1; i <= 62; i++) begin
      if (i % 5 == 0) step(1, 1, 0); else step(0, 0, 0);
      if (i == 62) expect_out(0, 0, 0, 2'b00, "quiet62");
    end
    step(1, 0, 0); expect_out(11, 0, 0, 2'b00, "quiet_break_up");
    step(0, 1, 0); expect_out(-7, 0, 0, 2'b00, "quiet_break_down");
    for (int i = 1; i <= 64; i++) begin
      if (i % 7 == 0) step(1, 1, 0); else step(0, 0, 0);
      if (i == 63) expect_out(0, 0, 0, 2'b00, "quiet63_not_locked");
      if (i == 64) expect_out(0, 1, 0, 2'b01, "quiet64_locked");
    end

    // TRK gains and unlock after 8 same-sign errors.
    step(1, 0, 0); expect_out(3, 1, 0, 2'b01, "trk_up");
    step(0, 0, 0); expect_out(1, 1, 0, 2'b01, "trk_up_idle");
    for (int k = 1; k <= 8; k++) begin
      step(0, 1, 0);
      if (k < 8) expect_out(-1 - k, 1, 0, 2'b01, "trk_down_run");
      else       expect_out(-9, 0, 0, 2'b00, "trk_unlock8");
    end
    for (int i = 1; i <= 64; i++) begin
      step(0, 0, 0);
      if (i == 63) expect_out(-7, 0, 0, 2'b00, "relock63");
      if (i == 64) expect_out(-7, 1, 0, 2'b01, "relock64");
    end
    for (int t = 1; t <= 8; t++) begin
      step(0, 1, 0);
      step(0, 1, 0);
      step(1, 0, 0);
      if (t == 1) expect_out(-6, 1, 0, 2'b01, "alt_first");
      if (t == 8) expect_out(-13, 1, 0, 2'b01, "alt_last");
    end

    // Hold freezes the loop; release restarts the quiet count.
    for (int i = 0; i < 10; i++) begin
      step(i[0], 0, 1); expect_out(-15, 0, 0, 2'b10, "hold");
    end
    step(0, 0, 0); expect_out(-15, 0, 0, 2'b00, "hold_release");
    for (int i = 1; i <= 64; i++) begin
      step(0, 0, 0);
      if (i == 63) expect_out(-15, 0, 0, 2'b00, "post_hold63");
      if (i == 64) expect_out(-15, 1, 0, 2'b01, "post_hold64");
    end

    // Positive clamp and immediate recovery.
    do_reset();
    for (int i = 1; i <= 8200; i++) begin
      step(1, 0, 0);
      if (i == 8190) expect_out(32767, 0, 0, 2'b00, "pos_edge_noclamp");
      if (i == 8191) expect_out(32767, 0, 1, 2'b00, "pos_out_clamp");
      if (i == 8192) expect_out(32767, 0, 1, 2'b00, "pos_acc_clamp");
      if (i == 8200) expect_out(32767, 0, 1, 2'b00, "pos_pinned");
    end
    step(0, 1, 0); expect_out(32756, 0, 0, 2'b00, "pos_recover");

    // Negative clamp and immediate recovery.
    do_reset();
    for (int i = 1; i <= 8200; i++) begin
      step(0, 1, 0);
      if (i == 8190) expect_out(-32767, 0, 0, 2'b00, "neg_edge_noclamp");
      if (i == 8191) expect_out(-32768, 0, 1, 2'b00, "neg_out_clamp");
      if (i == 8200) expect_out(-32768, 0, 1, 2'b00, "neg_pinned");
    end
    step(1, 0, 0); expect_out(-32757, 0, 0, 2'b00, "neg_recover");

    step(0, 0, 0);
    repeat (2) @(negedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
